// File: rtl/adc_scanner_if.sv
// adc_scanner_if
//   Groups the two buses of the ADC channel scanner.
//   SPI side : trig (frame request), wrData (command word), rdData (frame
//              result), spiSS (slave select from the SPI master, asynchronous).
//   CPU side : rdAddr (result select), rdValue / rdFresh (selected result and
//              its fresh flag), rdAck (clears the selected fresh flag).
//   master modport : the scanner itself.
//   slave modport  : the SPI master plus the CPU-side reader.
interface adc_scanner_if;
    logic        trig;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        spiSS;
    logic [2:0]  rdAddr;
    logic [11:0] rdValue;
    logic        rdFresh;
    logic        rdAck;

    modport master (
        output trig, wrData, rdValue, rdFresh,
        input  rdData, spiSS, rdAddr, rdAck
    );

    modport slave (
        input  trig, wrData, rdValue, rdFresh,
        output rdData, spiSS, rdAddr, rdAck
    );
endinterface

// File: rtl/adc_scanner.sv
// adc_scanner
//   Autonomous channel scanner in front of the 16-bit SPI ADC master. Every
//   PERIOD clocks it walks the enabled channels in ascending order, issues one
//   SPI frame per channel, detects frame completion from the slave-select
//   line and stores each 12-bit result with a fresh flag for the CPU.
//
//   Ports:
//     clk, resn   clock and asynchronous active-low reset
//     enable      run scanning (tick counter held at 0 while low)
//     chanMask    enabled channels, bit n = channel n
//     scanDone    one-cycle pulse after the last channel of a scan is stored
//     overrun     sticky, a tick arrived while a scan was still running
//     timeoutErr  sticky, SS never fell within TIMEOUT clocks of trig
//     errClr      one-cycle pulse clearing both sticky flags
//     bus         adc_scanner_if.master (SPI frame handshake + result readback)
module adc_scanner #(
    parameter int CHANNELS = 8,
    parameter int PERIOD   = 100000,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          resn,
    input  logic          enable,
    input  logic [7:0]    chanMask,
    output logic          scanDone,
    output logic          overrun,
    output logic          timeoutErr,
    input  logic          errClr,
    adc_scanner_if.master bus
);

    localparam int PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PER_W-1:0] TICK_AT  = PER_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]       CH_VALID = 8'((9'd1 << CHANNELS) - 9'd1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LO,
        WAIT_HI,
        STORE
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              ss_meta;
    logic              ss_s;
    logic [PER_W-1:0]  tick_cnt;
    logic              tick;
    logic [TO_W-1:0]   to_cnt;

    logic [7:0]        live_mask;
    logic [7:0]        scan_mask;
    logic [2:0]        ch;
    logic [2:0]        first_ch;
    logic [2:0]        next_ch;
    logic              has_next;

    logic              trig_q;
    logic [15:0]       wr_data_q;
    logic [11:0]       result [8];
    logic [7:0]        fresh;

    logic              start_scan;
    logic              frame_started;
    logic              frame_timeout;
    logic              do_store;
    logic              scan_end;

    // Bits 15:12 of a frame carry no conversion data.
    logic [3:0]        unused_rd_bits;
    assign unused_rd_bits = bus.rdData[15:12];

    // SS comes from the SCLK domain; only the synchronised copy is used.
    // Reset to 1 because an idle SPI master holds SS high.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            ss_meta <= 1'b1;
            ss_s    <= 1'b1;
        end else begin
            ss_meta <= bus.spiSS;
            ss_s    <= ss_meta;
        end
    end

    // Scan tick generator; a tick is the cycle the counter sits at PERIOD-1.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + PER_W'(1);
        end
    end

    assign tick      = (tick_cnt == TICK_AT);
    assign live_mask = chanMask & CH_VALID;

    // Lowest enabled channel of the live mask (scan start) and next enabled
    // channel above ch in the latched mask (scan continuation). Walking from
    // the top down lets the lowest qualifying bit win.
    always_comb begin
        first_ch = 3'd0;
        next_ch  = ch;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (live_mask[i]) begin
                first_ch = 3'(i);
            end
            if (scan_mask[i] && (3'(i) > ch)) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus one-cycle action strobes for the datapath.
    // A frame that starts on the same cycle the timeout expires is accepted.
    always_comb begin
        next_state    = state;
        start_scan    = 1'b0;
        frame_started = 1'b0;
        frame_timeout = 1'b0;
        do_store      = 1'b0;
        scan_end      = 1'b0;
        case (state)
            IDLE: begin
                if (tick && (live_mask != 8'd0)) begin
                    start_scan = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (!ss_s) begin
                    frame_started = 1'b1;
                    next_state    = WAIT_HI;
                end else if (to_cnt == TO_LAST) begin
                    frame_timeout = 1'b1;
                    next_state    = IDLE;
                end
            end
            WAIT_HI: begin
                if (ss_s) begin
                    next_state = STORE;
                end
            end
            STORE: begin
                do_store = 1'b1;
                if (has_next) begin
                    next_state = REQ;
                end else begin
                    scan_end   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame request datapath. trig drops as soon as the frame is seen to
    // start, so it is always low again before SS can rise; wrData holds its
    // value until the next REQ.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            trig_q    <= 1'b0;
            wr_data_q <= '0;
            to_cnt    <= '0;
            scan_mask <= '0;
            ch        <= '0;
            scanDone  <= 1'b0;
        end else begin
            scanDone <= scan_end;
            if (start_scan) begin
                scan_mask <= live_mask;
                ch        <= first_ch;
            end
            if (do_store && has_next) begin
                ch <= next_ch;
            end
            if (state == REQ) begin
                wr_data_q <= {4'b0000, 1'b1, 1'b1, ch, 7'b0000000};
                trig_q    <= 1'b1;
                to_cnt    <= '0;
            end
            if (state == WAIT_LO) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (frame_started || frame_timeout) begin
                trig_q <= 1'b0;
            end
        end
    end

    // Result registers and fresh flags; a store beats a same-cycle rdAck.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int n = 0; n < 8; n++) begin
                result[n] <= '0;
            end
            fresh <= '0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (do_store && (ch == 3'(n))) begin
                    result[n] <= bus.rdData[11:0];
                    fresh[n]  <= 1'b1;
                end else if (bus.rdAck && (bus.rdAddr == 3'(n))) begin
                    fresh[n] <= 1'b0;
                end
            end
        end
    end

    // Sticky error flags; a new event beats a same-cycle errClr.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            overrun    <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (errClr) begin
                overrun <= 1'b0;
            end
            if (frame_timeout) begin
                timeoutErr <= 1'b1;
            end else if (errClr) begin
                timeoutErr <= 1'b0;
            end
        end
    end

    assign bus.trig    = trig_q;
    assign bus.wrData  = wr_data_q;
    assign bus.rdValue = result[bus.rdAddr];
    assign bus.rdFresh = fresh[bus.rdAddr];

endmodule

// File: tb/tb_adc_scanner.sv
// tb_adc_scanner
//   Self-checking bench for adc_scanner. A behavioural SPI master answers
//   each trig with an SS low pulse and a per-channel response word; the
//   expected command word of every frame is queued when a scan is set up and
//   popped when the scanner issues the frame. Results are read back through
//   the CPU-side bus after each scan.
module tb_adc_scanner;

    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resn;
    logic       enable;
    logic [7:0] chanMask;
    logic       scanDone;
    logic       overrun;
    logic       timeoutErr;
    logic       errClr;

    adc_scanner_if bus();

    adc_scanner #(
        .CHANNELS (8),
        .PERIOD   (PERIOD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .resn       (resn),
        .enable     (enable),
        .chanMask   (chanMask),
        .scanDone   (scanDone),
        .overrun    (overrun),
        .timeoutErr (timeoutErr),
        .errClr     (errClr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          testCount  = 0;
    int          failCount  = 0;
    int          frameCount = 0;
    int          doneCount  = 0;
    logic [15:0] expQ [$];

    // SPI master model controls.
    bit          spiRespond = 1'b1;
    int          ssDelay    = 2;
    int          frameLen   = 8;
    int          ackCh      = -1;
    logic [15:0] respTable [8];

    // rdAck/rdAddr are shared by the main sequence and the SPI model.
    logic       mainAck   = 1'b0;
    logic [2:0] mainAddr  = 3'd0;
    logic       modelAck  = 1'b0;
    logic [2:0] modelAddr = 3'd0;
    assign bus.rdAck  = mainAck | modelAck;
    assign bus.rdAddr = modelAck ? modelAddr : mainAddr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sets the channel mask and queues the command word of each frame the
    // next scan must issue, lowest channel first.
    task automatic applyStimulus(input logic [7:0] mask);
        chanMask = mask;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                expQ.push_back(16'h0C00 | (16'(c) << 7));
            end
        end
    endtask

    task automatic checkChannel(input int n, input logic [11:0] value, input logic freshBit);
        mainAddr = 3'(n);
        #1;
        checkOutput($sformatf("ch%0d value", n), 32'(bus.rdValue), 32'(value));
        checkOutput($sformatf("ch%0d fresh", n), 32'(bus.rdFresh), 32'(freshBit));
    endtask

    task automatic ackChannel(input int n);
        @(negedge clk);
        mainAddr = 3'(n);
        mainAck  = 1'b1;
        @(negedge clk);
        mainAck  = 1'b0;
    endtask

    task automatic pulseErrClr();
        @(negedge clk);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        #1;
    endtask

    // Waits for a scanDone pulse, then checks that it lasted one cycle.
    task automatic waitScanDone(input int maxCycles, input string tag);
        int n = 0;
        while (scanDone !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " scanDone seen"}, 32'(scanDone), 32'd1);
        @(negedge clk);
        checkOutput({tag, " scanDone width"}, 32'(scanDone), 32'd0);
    endtask

    always @(negedge clk) begin
        if (resn === 1'b1 && scanDone === 1'b1) begin
            doneCount++;
        end
    end

    task automatic waitModel(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (!resn) break;
        end
    endtask

    // One SPI frame: pop and compare the expected command, pull SS low,
    // present the response, release SS. Optionally pulses rdAck for the
    // frame's channel in the exact cycle the scanner stores it.
    task automatic serveFrame();
        logic [15:0] cmd;
        logic [2:0]  fch;
        cmd = bus.wrData;
        fch = cmd[9:7];
        frameCount++;
        checkOutput("frame expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
            checkOutput($sformatf("frame %0d command", frameCount), 32'(cmd), 32'(expQ.pop_front()));
        end
        waitModel(ssDelay);
        if (resn) begin
            bus.rdData = respTable[fch];
            bus.spiSS  = 1'b0;
            waitModel(frameLen);
        end
        bus.spiSS = 1'b1;
        if (resn && int'(fch) == ackCh) begin
            waitModel(3);
            modelAddr = fch;
            modelAck  = 1'b1;
            waitModel(1);
            modelAck  = 1'b0;
        end
    endtask

    initial begin
        bus.spiSS  = 1'b1;
        bus.rdData = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!resn) begin
                bus.spiSS = 1'b1;
            end else if (spiRespond && bus.trig === 1'b1) begin
                serveFrame();
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f0;
        int d0;
        int n;

        resn     = 1'b0;
        enable   = 1'b0;
        errClr   = 1'b0;
        chanMask = 8'h00;
        for (int c = 0; c < 8; c++) respTable[c] = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset trig", 32'(bus.trig), 32'd0);
        checkOutput("reset wrData", 32'(bus.wrData), 32'd0);
        checkOutput("reset scanDone", 32'(scanDone), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset timeoutErr", 32'(timeoutErr), 32'd0);
        checkChannel(0, 12'h000, 1'b0);
        resn = 1'b1;
        @(negedge clk);

        // Single channel, two consecutive ticks
        $display("[TB] single channel");
        respTable[2] = 16'h0ABC;
        f0 = frameCount;
        d0 = doneCount;
        applyStimulus(8'h04);
        applyStimulus(8'h04);
        enable = 1'b1;
        waitScanDone(2 * PERIOD, "single 1");
        waitScanDone(2 * PERIOD, "single 2");
        enable = 1'b0;
        checkOutput("single frames", 32'(frameCount - f0), 32'd2);
        checkOutput("single scanDones", 32'(doneCount - d0), 32'd2);
        checkOutput("single wrData", 32'(bus.wrData), 32'h0D00);
        checkChannel(2, 12'hABC, 1'b1);
        checkChannel(3, 12'h000, 1'b0);
        ackChannel(2);
        checkChannel(2, 12'hABC, 1'b0);

        // Full scan of all eight channels
        $display("[TB] full scan");
        for (int c = 0; c < 8; c++) respTable[c] = 16'h0100 + 16'(c);
        @(negedge clk);
        f0 = frameCount;
        d0 = doneCount;
        applyStimulus(8'hFF);
        enable = 1'b1;
        waitScanDone(2 * PERIOD, "full");
        enable = 1'b0;
        checkOutput("full frames", 32'(frameCount - f0), 32'd8);
        checkOutput("full scanDones", 32'(doneCount - d0), 32'd1);
        checkOutput("full overrun", 32'(overrun), 32'd0);
        for (int c = 0; c < 8; c++) checkChannel(c, 12'h100 + 12'(c), 1'b1);

        // Sparse mask, changed while channel 0 is in flight
        $display("[TB] sparse mask");
        respTable[0] = 16'h0A00;
        respTable[1] = 16'h0A01;
        respTable[7] = 16'h0A07;
        @(negedge clk);
        f0 = frameCount;
        applyStimulus(8'h81);
        enable = 1'b1;
        n = 0;
        while (frameCount < f0 + 1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sparse first frame", 32'(frameCount - f0), 32'd1);
        applyStimulus(8'h02);
        waitScanDone(2 * PERIOD, "sparse 1");
        checkOutput("sparse first scan frames", 32'(frameCount - f0), 32'd2);
        checkChannel(0, 12'hA00, 1'b1);
        checkChannel(7, 12'hA07, 1'b1);
        checkChannel(1, 12'h101, 1'b1);
        waitScanDone(2 * PERIOD, "sparse 2");
        enable = 1'b0;
        checkOutput("sparse total frames", 32'(frameCount - f0), 32'd3);
        checkChannel(1, 12'hA01, 1'b1);

        // Timeout: SS never falls
        $display("[TB] timeout");
        spiRespond = 1'b0;
        @(negedge clk);
        f0 = frameCount;
        d0 = doneCount;
        chanMask = 8'h01;
        enable = 1'b1;
        n = 0;
        while (bus.trig !== 1'b1 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout trig raised", 32'(bus.trig), 32'd1);
        n = 0;
        while (bus.trig === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        enable = 1'b0;
        checkOutput("timeout trig high cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout flag", 32'(timeoutErr), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("timeout no scanDone", 32'(doneCount - d0), 32'd0);
        checkOutput("timeout no frame", 32'(frameCount - f0), 32'd0);
        pulseErrClr();
        checkOutput("timeout errClr", 32'(timeoutErr), 32'd0);
        spiRespond = 1'b1;

        // Overrun: frames long enough that the next tick lands mid-scan;
        // rdAck for channel 1 coincides with its store.
        $display("[TB] overrun");
        respTable[0] = 16'hF200;
        respTable[1] = 16'hF201;
        frameLen = 120;
        ackCh = 1;
        @(negedge clk);
        f0 = frameCount;
        d0 = doneCount;
        applyStimulus(8'h03);
        enable = 1'b1;
        waitScanDone(3 * PERIOD, "overrun");
        enable = 1'b0;
        ackCh = -1;
        checkOutput("overrun flag", 32'(overrun), 32'd1);
        checkOutput("overrun frames", 32'(frameCount - f0), 32'd2);
        checkOutput("overrun scanDones", 32'(doneCount - d0), 32'd1);
        checkChannel(1, 12'h201, 1'b1);
        checkChannel(0, 12'h200, 1'b1);
        ackChannel(0);
        checkChannel(0, 12'h200, 1'b0);
        pulseErrClr();
        checkOutput("overrun errClr", 32'(overrun), 32'd0);
        frameLen = 8;

        // Reset while waiting for SS to rise
        $display("[TB] reset mid-frame");
        frameLen = 40;
        @(negedge clk);
        applyStimulus(8'h01);
        enable = 1'b1;
        n = 0;
        while (bus.spiSS !== 1'b0 && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset test SS low", 32'(bus.spiSS), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("reset test trig dropped", 32'(bus.trig), 32'd0);
        #2;
        resn = 1'b0;
        #1;
        checkOutput("midreset trig", 32'(bus.trig), 32'd0);
        checkOutput("midreset wrData", 32'(bus.wrData), 32'd0);
        for (int c = 0; c < 8; c++) checkChannel(c, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        resn = 1'b1;
        frameLen = 8;
        respTable[0] = 16'h0B00;
        respTable[1] = 16'h0B01;
        f0 = frameCount;
        applyStimulus(8'h03);
        waitScanDone(2 * PERIOD, "post reset");
        enable = 1'b0;
        checkOutput("post reset frames", 32'(frameCount - f0), 32'd2);
        checkChannel(0, 12'hB00, 1'b1);
        checkChannel(1, 12'hB01, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
